// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, UNROLL bits per
// cycle, fixed latency of XLEN/UNROLL+1 cycles from the request cycle to resp_v.
module muldiv_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_v,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            resp_v,
    output logic [XLEN-1:0] rd_data
);

    localparam int unsigned STEPS = XLEN / UNROLL;
    localparam int unsigned CW    = $clog2(STEPS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_r;
    logic            neg_r;    // product sign, or quotient sign
    logic            rneg_r;   // remainder sign (sign of dividend)
    logic            div0_r;
    logic [XLEN-1:0] mag_r;    // multiplicand or divisor magnitude
    logic [XLEN:0]   hi_r;     // product high half / partial remainder
    logic [XLEN-1:0] lo_r;     // multiplier / dividend shifting into quotient

    logic            is_div, sgn_a, sgn_b, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0]   hi_n, sum;
    logic [XLEN-1:0] lo_n;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quot, rem, result;

    // Decode operand signedness and magnitudes for the op being offered
    always_comb begin
        is_div = funct3[2];
        sgn_a  = is_div ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        sgn_b  = is_div ? ~funct3[0] : (funct3 == 3'b001);
        a_neg  = sgn_a & rs1_data[XLEN-1];
        b_neg  = sgn_b & rs2_data[XLEN-1];
        abs_a  = a_neg ? -rs1_data : rs1_data;
        abs_b  = b_neg ? -rs2_data : rs2_data;
    end

    // UNROLL iterations of shift-add or restoring-divide step
    always_comb begin
        hi_n = hi_r;
        lo_n = lo_r;
        sum  = '0;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (op_r[2]) begin
                sum  = {hi_n[XLEN-1:0], lo_n[XLEN-1]};
                lo_n = {lo_n[XLEN-2:0], 1'b0};
                if (sum >= {1'b0, mag_r}) begin
                    sum     = sum - {1'b0, mag_r};
                    lo_n[0] = 1'b1;
                end
                hi_n = sum;
            end else begin
                sum  = hi_n + (lo_n[0] ? {1'b0, mag_r} : '0);
                lo_n = {sum[0], lo_n[XLEN-1:1]};
                hi_n = {1'b0, sum[XLEN:1]};
            end
        end
    end

    // Sign correction and result select from the final step values
    always_comb begin
        prod = {hi_n[XLEN-1:0], lo_n};
        if (neg_r) begin
            prod = -prod;
        end
        // divide by zero leaves remainder = |a|, so sign correction restores rs1_data
        quot = div0_r ? '1 : (neg_r ? -lo_n : lo_n);
        rem  = rneg_r ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
        if (op_r[2]) begin
            result = op_r[1] ? rem : quot;
        end else begin
            result = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Control FSM with registered busy/resp_v/rd_data and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            resp_v  <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_v <= 1'b0;
                    if (req_v && !flush) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        op_r   <= funct3;
                        neg_r  <= a_neg ^ b_neg;
                        rneg_r <= a_neg;
                        div0_r <= (rs2_data == '0);
                        hi_r   <= '0;
                        if (is_div) begin
                            lo_r  <= abs_a;
                            mag_r <= abs_b;
                        end else begin
                            lo_r  <= abs_b;
                            mag_r <= abs_a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        hi_r <= hi_n;
                        lo_r <= lo_n;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(STEPS - 1)) begin
                            state   <= DONE;
                            cnt     <= '0;
                            resp_v  <= 1'b1;
                            rd_data <= result;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    resp_v <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    resp_v <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table + random ops through a
// scoreboard on an XLEN=32/UNROLL=1 instance, plus hand sequences for flush,
// reset and back-to-back timing on an UNROLL=4 instance.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_v_a, flush_a, busy_a, resp_v_a;
    logic [2:0]  funct3_a;
    logic [31:0] rs1_a, rs2_a, rd_data_a;
    logic        req_v_b, flush_b, busy_b, resp_v_b;
    logic [2:0]  funct3_b;
    logic [31:0] rs1_b, rs2_b, rd_data_b;

    muldiv_unit #(.XLEN(32), .UNROLL(1)) dut_a (
        .clk(clk), .reset(reset), .req_v(req_v_a), .funct3(funct3_a),
        .rs1_data(rs1_a), .rs2_data(rs2_a), .flush(flush_a),
        .busy(busy_a), .resp_v(resp_v_a), .rd_data(rd_data_a)
    );

    muldiv_unit #(.XLEN(32), .UNROLL(4)) dut_b (
        .clk(clk), .reset(reset), .req_v(req_v_b), .funct3(funct3_b),
        .rs1_data(rs1_b), .rs2_data(rs2_b), .flush(flush_b),
        .busy(busy_b), .resp_v(resp_v_b), .rd_data(rd_data_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference using native wide arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as, bs, bu;
        logic [63:0] p;
        logic [31:0] r;
        as = {{32{a[31]}}, a};
        bs = {{32{b[31]}}, b};
        bu = {32'b0, b};
        r  = '0;
        case (f)
            3'd0: begin p = as * bs; r = p[31:0]; end
            3'd1: begin p = as * bs; r = p[63:32]; end
            3'd2: begin p = as * bu; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int unsigned resp_cnt_a = 0;

    // Scoreboard monitor: every response must match the oldest pending op and arrive 33 cycles after its request cycle
    always @(negedge clk) begin
        if (!reset && resp_v_a) begin
            resp_cnt_a++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_v with rd_data 0x%0h, required no response", rd_data_a);
            end else begin
                e = sb.pop_front();
                check({e.name, "_data"}, rd_data_a, e.data);
                check({e.name, "_latency"}, cyc - e.cyc, 33);
            end
        end
    end

    // Called at a negedge; waits for idle, presents one request cycle
    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
        int n = 0;
        while (busy_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_wait"}, busy_a, 0);
        funct3_a = f; rs1_a = a; rs2_a = b; req_v_a = 1'b1;
        sb.push_back('{data: exp, cyc: cyc, name: name});
        @(negedge clk);
        req_v_a = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        string       name;
    } vec_t;

    vec_t vecs[18];
    logic [31:0] specials[5];
    logic [31:0] ra, rb, rd_before;
    logic [2:0]  rf;
    int unsigned k, k2, rc, busy_cnt;
    int          n;

    initial begin
        vecs[0]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_m1"};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1"};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_m1x2"};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"};
        vecs[5]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        vecs[6]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"};
        vecs[7]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0"};
        vecs[8]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_by0"};
        vecs[9]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, "div_neg_by0"};
        vecs[10] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, "rem_neg_by0"};
        vecs[11] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_minmin"};
        vecs[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minmin"};
        vecs[13] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min"};
        vecs[14] = '{3'd5, 32'd100,       32'd7,         32'h0000_000E, "divu_100_7"};
        vecs[15] = '{3'd7, 32'd100,       32'd7,         32'h0000_0002, "remu_100_7"};
        vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"};
        vecs[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, "rem_7_m2"};
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        reset = 1'b1;
        req_v_a = 1'b0; flush_a = 1'b0; funct3_a = '0; rs1_a = '0; rs2_a = '0;
        req_v_b = 1'b0; flush_b = 1'b0; funct3_b = '0; rs1_b = '0; rs2_b = '0;
        repeat (2) @(negedge clk);

        // reset dominates a pending request
        req_v_a = 1'b1; rs1_a = 32'd5; rs2_a = 32'd5;
        req_v_b = 1'b1;
        @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_resp_v", resp_v_a, 0);
        check("rst_rd_data", rd_data_a, 0);
        check("rst_busy_b", busy_b, 0);
        req_v_a = 1'b0; req_v_b = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy_a, 0);

        // MUL 7 x -3: busy width, request ignored mid-flight
        funct3_a = 3'd0; rs1_a = 32'd7; rs2_a = 32'hFFFF_FFFD; req_v_a = 1'b1;
        sb.push_back('{data: 32'hFFFF_FFEB, cyc: cyc, name: "mul_7_m3"});
        @(negedge clk);
        req_v_a = 1'b0;
        busy_cnt = 0; n = 0;
        while (busy_a && n < 100) begin
            busy_cnt++;
            if (busy_cnt == 5) begin
                funct3_a = 3'd5; rs1_a = 32'd9; rs2_a = 32'd2; req_v_a = 1'b1;
            end else begin
                req_v_a = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req_v_a = 1'b0;
        check("mul_busy_cycles", busy_cnt, 33);
        repeat (3) @(negedge clk);
        check("rd_data_hold", rd_data_a, 32'hFFFF_FFEB);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end
        drain();

        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            send(rf, ra, rb, ref_op(rf, ra, rb), $sformatf("rand%0d_f%0d", i, rf));
        end
        drain();

        // flush on the 10th RUN cycle, then new op the very next cycle
        funct3_a = 3'd5; rs1_a = 32'hFFFF_FFFF; rs2_a = 32'd3; req_v_a = 1'b1;
        k = cyc;
        @(negedge clk);
        req_v_a = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_run_cycle", cyc - k, 10);
        rd_before = rd_data_a;
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        check("flush_busy_low", busy_a, 0);
        check("flush_rd_hold", rd_data_a, rd_before);
        rc = resp_cnt_a;
        send(3'd5, 32'd100, 32'd7, 32'h0000_000E, "divu_after_flush");
        repeat (31) @(negedge clk);
        check("flush_no_resp", resp_cnt_a - rc, 0);
        drain();

        // flush coinciding with req_v in IDLE drops the request
        funct3_a = 3'd0; rs1_a = 32'd3; rs2_a = 32'd3; req_v_a = 1'b1; flush_a = 1'b1;
        @(negedge clk);
        req_v_a = 1'b0; flush_a = 1'b0;
        check("flush_idle_drop", busy_a, 0);
        rc = resp_cnt_a;
        repeat (40) @(negedge clk);
        check("flush_idle_no_resp", resp_cnt_a - rc, 0);

        // reset mid-RUN discards the op
        funct3_a = 3'd0; rs1_a = 32'd3; rs2_a = 32'd5; req_v_a = 1'b1;
        @(negedge clk);
        req_v_a = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_busy", busy_a, 0);
        check("midrun_rst_rd", rd_data_a, 0);
        reset = 1'b0;
        rc = resp_cnt_a;
        repeat (40) @(negedge clk);
        check("midrun_rst_no_resp", resp_cnt_a - rc, 0);

        // UNROLL=4: 9-cycle latency, req_v held through DONE
        funct3_b = 3'd0; rs1_b = 32'd12345; rs2_b = 32'd678; req_v_b = 1'b1;
        k = cyc; n = 0;
        @(negedge clk);
        while (!resp_v_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_mul_resp_seen", resp_v_b, 1);
        check("b_mul_data", rd_data_b, 32'h007F_B6F6);
        check("b_mul_latency", cyc - k, 9);
        check("b_done_busy", busy_b, 1);
        rs1_b = 32'd100; rs2_b = 32'd3;
        @(negedge clk);
        check("b_resp_pulse", resp_v_b, 0);
        check("b_idle_after_done", busy_b, 0);
        k2 = cyc;
        @(negedge clk);
        req_v_b = 1'b0;
        check("b_second_accept", busy_b, 1);
        n = 0;
        while (!resp_v_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_second_data", rd_data_b, 32'd300);
        check("b_second_latency", cyc - k2, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
